// File: rtl/ipm_host_pkg.sv
// Shared encodings for the ipm bridge-bus host master: request ops, bridge
// address map, command bytes, FSM state codes and small lane helpers.
package ipm_host_pkg;

  // Request op encodings
  localparam logic [1:0] OP_WRITE    = 2'd0;
  localparam logic [1:0] OP_READ     = 2'd1;
  localparam logic [1:0] OP_START    = 2'd2;
  localparam logic [1:0] OP_WAIT_INT = 2'd3;

  // Bridge address map
  localparam logic [3:0] ADDR_DATA0 = 4'h0;
  localparam logic [3:0] ADDR_DATA1 = 4'h1;
  localparam logic [3:0] ADDR_DATA2 = 4'h2;
  localparam logic [3:0] ADDR_DATA3 = 4'h3;
  localparam logic [3:0] ADDR_CONF  = 4'h4;
  localparam logic [3:0] ADDR_CMD   = 4'h5;

  // Command register values
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_START = 8'h04;

  // Top FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CONF  = 3'd1;
  localparam logic [2:0] ST_WBYTE = 3'd2;
  localparam logic [2:0] ST_CMD   = 3'd3;
  localparam logic [2:0] ST_RBYTE = 3'd4;
  localparam logic [2:0] ST_WAITI = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // Single-access engine phases
  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_SETUP  = 2'd1;
  localparam logic [1:0] PH_STROBE = 2'd2;
  localparam logic [1:0] PH_HOLD   = 2'd3;

  // Bridge address of data byte lane i
  function automatic logic [3:0] lane_addr(input logic [1:0] i);
    case (i)
      2'd0:    lane_addr = ADDR_DATA0;
      2'd1:    lane_addr = ADDR_DATA1;
      2'd2:    lane_addr = ADDR_DATA2;
      default: lane_addr = ADDR_DATA3;
    endcase
  endfunction

  // Byte lane i of a 32-bit word, lane 0 = bits [7:0]
  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] i);
    byte_lane = w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ipm_host_bus_cycle.sv
// Single bridge-bus access engine: SETUP (1) / STROBE (STROBE_CYC) / HOLD (1).
// done is high during HOLD; a new go accepted in HOLD chains with no gap.
module ipm_host_bus_cycle
  import ipm_host_pkg::*;
#(
  parameter int unsigned STROBE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       is_read,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic [3:0] bus_addr,
  output logic       bus_rd,
  output logic       bus_wr,
  output logic [7:0] bus_data_o,
  output logic       bus_data_oe,
  input  logic [7:0] bus_data_i
);

  localparam int unsigned CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

  logic [1:0]    phase, phase_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          rd_q, rd_nx;
  logic          done_nx;
  logic [7:0]    rdata_nx;
  logic [3:0]    addr_nx;
  logic          bus_rd_nx, bus_wr_nx, oe_nx;
  logic [7:0]    data_o_nx;

  // Phase sequencing and next values of the registered bus pins
  always_comb begin
    phase_nx  = phase;
    cnt_nx    = cnt;
    rd_nx     = rd_q;
    done_nx   = 1'b0;
    rdata_nx  = rdata;
    addr_nx   = bus_addr;
    bus_rd_nx = 1'b0;
    bus_wr_nx = 1'b0;
    oe_nx     = bus_data_oe;
    data_o_nx = bus_data_o;
    case (phase)
      PH_IDLE, PH_HOLD: begin
        if (go) begin
          phase_nx  = PH_SETUP;
          rd_nx     = is_read;
          addr_nx   = addr;
          data_o_nx = is_read ? 8'h00 : wdata;
          oe_nx     = ~is_read;
        end else begin
          phase_nx  = PH_IDLE;
          addr_nx   = 4'h0;
          data_o_nx = 8'h00;
          oe_nx     = 1'b0;
        end
      end
      PH_SETUP: begin
        phase_nx  = PH_STROBE;
        cnt_nx    = CW'(STROBE_CYC - 1);
        bus_rd_nx = rd_q;
        bus_wr_nx = ~rd_q;
      end
      PH_STROBE: begin
        if (cnt == CW'(0)) begin
          // last strobe cycle: capture slave data and drop the strobe
          phase_nx = PH_HOLD;
          done_nx  = 1'b1;
          if (rd_q) rdata_nx = bus_data_i;
        end else begin
          cnt_nx    = cnt - CW'(1);
          bus_rd_nx = rd_q;
          bus_wr_nx = ~rd_q;
        end
      end
    endcase
  end

  // Engine state and bus pin registers
  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= PH_IDLE;
      cnt         <= '0;
      rd_q        <= 1'b0;
      done        <= 1'b0;
      rdata       <= 8'h00;
      bus_addr    <= 4'h0;
      bus_rd      <= 1'b0;
      bus_wr      <= 1'b0;
      bus_data_o  <= 8'h00;
      bus_data_oe <= 1'b0;
    end else begin
      phase       <= phase_nx;
      cnt         <= cnt_nx;
      rd_q        <= rd_nx;
      done        <= done_nx;
      rdata       <= rdata_nx;
      bus_addr    <= addr_nx;
      bus_rd      <= bus_rd_nx;
      bus_wr      <= bus_wr_nx;
      bus_data_o  <= data_o_nx;
      bus_data_oe <= oe_nx;
    end
  end

endmodule

// File: rtl/ipm_host_master.sv
// Host master for the ipm 4-bit-address / 8-bit-data bridge bus.
// Serialises WRITE/READ/START requests into byte accesses and waits on int.
// Optional: define IPM_HOST_TIMEOUT_EN to give WAIT_INT a TIMEOUT_CYC timeout.
module ipm_host_master
  import ipm_host_pkg::*;
#(
  parameter int unsigned STROBE_CYC = 4
`ifdef IPM_HOST_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1_000_000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_conf,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic [3:0]  bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic        bus_rst,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_int
);

  logic [2:0]  state, state_nx;
  logic [1:0]  op_q, op_nx;
  logic [4:0]  conf_q, conf_nx;
  logic [31:0] data_q, data_nx;
  logic [1:0]  idx, idx_nx;
  logic [23:0] acc, acc_nx;
  logic [2:0]  rst_cnt, rst_cnt_nx;
  logic        bus_rst_nx;
  logic        int_s1, int_s2, int_s1_nx, int_s2_nx;
  logic        req_ready_nx, resp_valid_nx, busy_nx;
  logic [31:0] resp_data_nx;
  logic        accept;

  logic        go, go_rd, acc_done;
  logic [3:0]  go_addr;
  logic [7:0]  go_wdata, acc_rdata;

`ifdef IPM_HOST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          resp_err_nx;
`endif

  assign accept = req_valid & req_ready;

  // Request sequencing: next state, access issue and response values
  always_comb begin
    state_nx     = state;
    op_nx        = op_q;
    conf_nx      = conf_q;
    data_nx      = data_q;
    idx_nx       = idx;
    acc_nx       = acc;
    resp_data_nx = resp_data;
    go           = 1'b0;
    go_rd        = 1'b0;
    go_addr      = 4'h0;
    go_wdata     = 8'h00;
    rst_cnt_nx   = (rst_cnt != 3'd0) ? rst_cnt - 3'd1 : 3'd0;
    bus_rst_nx   = (rst_cnt > 3'd1);
    int_s1_nx    = bus_int;
    int_s2_nx    = int_s1;
`ifdef IPM_HOST_TIMEOUT_EN
    tcnt_nx      = tcnt;
    resp_err_nx  = resp_err;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) begin
          op_nx   = req_op;
          conf_nx = req_conf;
          data_nx = req_data;
          idx_nx  = 2'd0;
`ifdef IPM_HOST_TIMEOUT_EN
          tcnt_nx = '0;
`endif
          case (req_op)
            OP_WRITE, OP_READ: begin
              state_nx = ST_CONF;
              go       = 1'b1;
              go_addr  = ADDR_CONF;
              go_wdata = {3'b000, req_conf};
            end
            OP_START: begin
              state_nx = ST_CMD;
              go       = 1'b1;
              go_addr  = ADDR_CMD;
              go_wdata = CMD_START;
            end
            default: begin
              // flush the synchroniser so the int level is freshly qualified
              state_nx  = ST_WAITI;
              int_s1_nx = 1'b0;
              int_s2_nx = 1'b0;
            end
          endcase
        end
      end
      ST_CONF: begin
        if (acc_done) begin
          go = 1'b1;
          if (op_q == OP_WRITE) begin
            state_nx = ST_WBYTE;
            go_addr  = lane_addr(2'd0);
            go_wdata = byte_lane(data_q, 2'd0);
          end else begin
            state_nx = ST_CMD;
            go_addr  = ADDR_CMD;
            go_wdata = CMD_READ;
          end
        end
      end
      ST_WBYTE: begin
        if (acc_done) begin
          go = 1'b1;
          if (idx == 2'd3) begin
            state_nx = ST_CMD;
            go_addr  = ADDR_CMD;
            go_wdata = CMD_WRITE;
          end else begin
            idx_nx   = idx + 2'd1;
            go_addr  = lane_addr(idx + 2'd1);
            go_wdata = byte_lane(data_q, idx + 2'd1);
          end
        end
      end
      ST_CMD: begin
        if (acc_done) begin
          if (op_q == OP_READ) begin
            state_nx = ST_RBYTE;
            idx_nx   = 2'd0;
            go       = 1'b1;
            go_rd    = 1'b1;
            go_addr  = lane_addr(2'd0);
          end else begin
            state_nx     = ST_DONE;
            resp_data_nx = 32'h0;
`ifdef IPM_HOST_TIMEOUT_EN
            resp_err_nx  = 1'b0;
`endif
          end
        end
      end
      ST_RBYTE: begin
        if (acc_done) begin
          if (idx == 2'd3) begin
            state_nx     = ST_DONE;
            resp_data_nx = {acc_rdata, acc};
`ifdef IPM_HOST_TIMEOUT_EN
            resp_err_nx  = 1'b0;
`endif
          end else begin
            // bytes arrive LSB first, shift in from the top
            acc_nx  = {acc_rdata, acc[23:8]};
            idx_nx  = idx + 2'd1;
            go      = 1'b1;
            go_rd   = 1'b1;
            go_addr = lane_addr(idx + 2'd1);
          end
        end
      end
      ST_WAITI: begin
        if (int_s2) begin
          state_nx     = ST_DONE;
          resp_data_nx = 32'h0;
`ifdef IPM_HOST_TIMEOUT_EN
          resp_err_nx  = 1'b0;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          state_nx     = ST_DONE;
          resp_data_nx = 32'h0;
          resp_err_nx  = 1'b1;
        end else begin
          tcnt_nx = tcnt + TW'(1);
`endif
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    resp_valid_nx = (state_nx == ST_DONE);
    busy_nx       = (state_nx != ST_IDLE);
    req_ready_nx  = (state_nx == ST_IDLE) && !bus_rst;
  end

  // FSM, request context and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_WRITE;
      conf_q     <= 5'h0;
      data_q     <= 32'h0;
      idx        <= 2'd0;
      acc        <= 24'h0;
      rst_cnt    <= 3'd4;
      bus_rst    <= 1'b1;
      int_s1     <= 1'b0;
      int_s2     <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= 32'h0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      op_q       <= op_nx;
      conf_q     <= conf_nx;
      data_q     <= data_nx;
      idx        <= idx_nx;
      acc        <= acc_nx;
      rst_cnt    <= rst_cnt_nx;
      bus_rst    <= bus_rst_nx;
      int_s1     <= int_s1_nx;
      int_s2     <= int_s2_nx;
      req_ready  <= req_ready_nx;
      resp_valid <= resp_valid_nx;
      resp_data  <= resp_data_nx;
      busy       <= busy_nx;
    end
  end

`ifdef IPM_HOST_TIMEOUT_EN
  // WAIT_INT timeout counter and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt     <= '0;
      resp_err <= 1'b0;
    end else begin
      tcnt     <= tcnt_nx;
      resp_err <= resp_err_nx;
    end
  end
`else
  assign resp_err = 1'b0;
`endif

  ipm_host_bus_cycle #(
    .STROBE_CYC (STROBE_CYC)
  ) u_bus (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .is_read     (go_rd),
    .addr        (go_addr),
    .wdata       (go_wdata),
    .done        (acc_done),
    .rdata       (acc_rdata),
    .bus_addr    (bus_addr),
    .bus_rd      (bus_rd),
    .bus_wr      (bus_wr),
    .bus_data_o  (bus_data_o),
    .bus_data_oe (bus_data_oe),
    .bus_data_i  (bus_data_i)
  );

endmodule

// File: tb/tb_ipm_host_master.sv
// Directed + randomized bench for ipm_host_master with a bus monitor and a
// byte-lane slave model. Define IPM_HOST_TIMEOUT_EN to cover the timeout path.
module tb_ipm_host_master;

  localparam int unsigned STROBE = 4;
  localparam logic [1:0] W_OP = 2'd0, R_OP = 2'd1, S_OP = 2'd2, I_OP = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_conf;
  logic [31:0] req_data;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_data;
  logic [3:0]  bus_addr;
  logic        bus_rd, bus_wr, bus_rst, bus_data_oe, bus_int;
  logic [7:0]  bus_data_o, bus_data_i;

  logic [7:0]  lanes [4];
  int          checks = 0;
  int          failures = 0;
  int          viol = 0;

  typedef struct {
    logic [3:0] a;
    logic       w;
    logic [7:0] d;
    int         len;
  } acc_t;
  acc_t mon_q[$];
  acc_t cur;
  bit   in_stb = 1'b0;

  ipm_host_master #(
    .STROBE_CYC (STROBE)
`ifdef IPM_HOST_TIMEOUT_EN
    , .TIMEOUT_CYC (50)
`endif
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_op (req_op),
    .req_conf (req_conf), .req_data (req_data),
    .resp_valid (resp_valid), .resp_data (resp_data), .resp_err (resp_err),
    .busy (busy), .bus_addr (bus_addr), .bus_rd (bus_rd), .bus_wr (bus_wr),
    .bus_rst (bus_rst), .bus_data_o (bus_data_o), .bus_data_oe (bus_data_oe),
    .bus_data_i (bus_data_i), .bus_int (bus_int)
  );

  always #5 clk = ~clk;

  // slave drives the addressed lane only while rd is high
  assign bus_data_i = bus_rd ? lanes[bus_addr[1:0]] : 8'h00;

  // bus monitor: records each strobe and flags protocol violations
  always @(negedge clk) begin
    if (bus_rd && bus_wr) viol++;
    if (bus_rd && bus_data_oe) viol++;
    if (bus_wr && !bus_data_oe) viol++;
    if (bus_rd || bus_wr) begin
      if (!in_stb) begin
        in_stb = 1'b1;
        cur.a = bus_addr; cur.w = bus_wr; cur.d = bus_data_o; cur.len = 1;
      end else begin
        cur.len++;
        if (bus_addr !== cur.a || bus_wr !== cur.w || (bus_wr && bus_data_o !== cur.d)) viol++;
      end
    end else if (in_stb) begin
      in_stb = 1'b0;
      mon_q.push_back(cur);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic acc_t mk(input logic [3:0] a, input logic w, input logic [7:0] d);
    acc_t e;
    e.a = a; e.w = w; e.d = d; e.len = STROBE;
    return e;
  endfunction

  // expected access list derived from the op, compared with the monitor log
  task automatic check_accesses(input string tag, input logic [1:0] op,
                                input logic [4:0] conf, input logic [31:0] d);
    acc_t exp_q[$];
    acc_t e, r;
    case (op)
      W_OP: begin
        exp_q.push_back(mk(4'h4, 1'b1, {3'b000, conf}));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(4'(i), 1'b1, d[8*i +: 8]));
        exp_q.push_back(mk(4'h5, 1'b1, 8'h01));
      end
      R_OP: begin
        exp_q.push_back(mk(4'h4, 1'b1, {3'b000, conf}));
        exp_q.push_back(mk(4'h5, 1'b1, 8'h02));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(4'(i), 1'b0, 8'h00));
      end
      S_OP: exp_q.push_back(mk(4'h5, 1'b1, 8'h04));
      default: ;
    endcase
    chk({tag, "_nacc"}, 32'(mon_q.size()), 32'(exp_q.size()));
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      r = mon_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_addr"}, 32'(r.a), 32'(e.a));
      chk({tag, "_kind"}, 32'(r.w), 32'(e.w));
      if (e.w) chk({tag, "_wdata"}, 32'(r.d), 32'(e.d));
      chk({tag, "_strobe_len"}, 32'(r.len), 32'(e.len));
    end
    mon_q.delete();
  endtask

  // issue one request and wait (bounded) for its response pulse
  task automatic do_req(input string tag, input logic [1:0] op, input logic [4:0] conf,
                        input logic [31:0] d, input int max_cyc, input int int_at,
                        output bit got, output int lat, output logic [31:0] rdata,
                        output logic err);
    int w = 0;
    got = 1'b0; lat = 0; rdata = 32'h0; err = 1'b0;
    while (!req_ready && w < 50) begin step(); w++; end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_conf = conf; req_data = d;
    step();
    req_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ready_drop"}, 32'(req_ready), 32'd0);
    for (int n = 1; n <= max_cyc; n++) begin
      if (int_at >= 0 && n - 1 == int_at) bus_int = 1'b1;
      step();
      if (resp_valid) begin
        got = 1'b1; lat = n; rdata = resp_data; err = resp_err;
        break;
      end
    end
    if (got) begin
      step();
      chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic reset_and_wait(input string tag);
    int w = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    while (!req_ready && w < 20) begin step(); w++; end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    mon_q.delete();
  endtask

  initial begin
    bit          got;
    int          lat;
    logic [31:0] rd, d;
    logic        err;
    logic [1:0]  op;
    logic [4:0]  conf;

    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_conf = 5'h0; req_data = 32'h0;
    bus_int = 1'b0;
    for (int i = 0; i < 4; i++) lanes[i] = 8'h00;
    repeat (3) step();

    // reset state
    chk("rst_bus_rst", 32'(bus_rst), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_flags", 32'({bus_rd, bus_wr, bus_data_oe, resp_valid, resp_err, busy}), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_data_o", 32'(bus_data_o), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);

    // bus_rst stays high for 4 cycles after rst falls, ready follows
    rst = 1'b0;
    chk("fall_bus_rst0", 32'(bus_rst), 32'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("fall_bus_rst", 32'(bus_rst), 32'd1);
      chk("fall_ready", 32'(req_ready), 32'd0);
    end
    step();
    chk("fall_bus_rst_low", 32'(bus_rst), 32'd0);
    chk("fall_ready_still_low", 32'(req_ready), 32'd0);
    step();
    chk("ready_up", 32'(req_ready), 32'd1);

    // directed WRITE
    mon_q.delete();
    do_req("wr", W_OP, 5'h03, 32'hA1B2C3D4, 100, -1, got, lat, rd, err);
    chk("wr_got", 32'(got), 32'd1);
    chk("wr_latency", 32'(lat), 32'd36);
    chk("wr_rdata", rd, 32'd0);
    chk("wr_err", 32'(err), 32'd0);
    check_accesses("wr", W_OP, 5'h03, 32'hA1B2C3D4);

    // directed READ
    lanes[0] = 8'h11; lanes[1] = 8'h22; lanes[2] = 8'h33; lanes[3] = 8'h44;
    do_req("rd", R_OP, 5'h05, 32'h0, 100, -1, got, lat, rd, err);
    chk("rd_got", 32'(got), 32'd1);
    chk("rd_latency", 32'(lat), 32'd36);
    chk("rd_data", rd, 32'h44332211);
    chk("rd_hold", resp_data, 32'h44332211);
    check_accesses("rd", R_OP, 5'h05, 32'h0);

    // START
    do_req("st", S_OP, 5'h1F, 32'hFFFF_FFFF, 100, -1, got, lat, rd, err);
    chk("st_latency", 32'(lat), 32'd6);
    chk("st_rdata", rd, 32'd0);
    check_accesses("st", S_OP, 5'h1F, 32'hFFFF_FFFF);

    // WAIT_INT with int raised 10 cycles after acceptance
    do_req("wi", I_OP, 5'h0, 32'h0, 100, 10, got, lat, rd, err);
    chk("wi_got", 32'(got), 32'd1);
    chk("wi_latency", 32'(lat), 32'd13);
    chk("wi_err", 32'(err), 32'd0);
    check_accesses("wi", I_OP, 5'h0, 32'h0);

    // WAIT_INT with int already high
    do_req("wi_hi", I_OP, 5'h0, 32'h0, 100, -1, got, lat, rd, err);
    chk("wi_hi_latency", 32'(lat), 32'd3);
    bus_int = 1'b0;
    repeat (4) step();

    // randomized WRITE/READ against the access/lane model
    for (int k = 0; k < 6; k++) begin
      op   = 2'($urandom_range(0, 1));
      conf = 5'($urandom);
      d    = $urandom;
      for (int i = 0; i < 4; i++) lanes[i] = 8'($urandom);
      do_req("rnd", op, conf, d, 100, -1, got, lat, rd, err);
      chk("rnd_latency", 32'(lat), 32'd36);
      chk("rnd_resp", rd, (op == R_OP) ? {lanes[3], lanes[2], lanes[1], lanes[0]} : 32'h0);
      check_accesses("rnd", op, conf, d);
    end

`ifdef IPM_HOST_TIMEOUT_EN
    do_req("to", I_OP, 5'h0, 32'h0, 200, -1, got, lat, rd, err);
    chk("to_got", 32'(got), 32'd1);
    chk("to_latency", 32'(lat), 32'd50);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rdata", rd, 32'd0);
`else
    do_req("to", I_OP, 5'h0, 32'h0, 1000, -1, got, lat, rd, err);
    chk("no_timeout", 32'(got), 32'd0);
    chk("no_timeout_busy", 32'(busy), 32'd1);
`endif
    reset_and_wait("rec");

    // reset during byte 2 of a WRITE, then a fresh READ
    req_valid = 1'b1; req_op = W_OP; req_conf = 5'h0A; req_data = 32'h5566_7788;
    step();
    req_valid = 1'b0;
    repeat (19) step();
    chk("mid_wr_strobe", 32'(bus_wr), 32'd1);
    chk("mid_wr_addr", 32'(bus_addr), 32'd2);
    rst = 1'b1;
    step();
    chk("abort_strobes", 32'({bus_rd, bus_wr}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_oe", 32'(bus_data_oe), 32'd0);
    rst = 1'b0;
    begin
      int w = 0;
      while (!req_ready && w < 20) begin step(); w++; end
    end
    mon_q.delete();
    for (int i = 0; i < 4; i++) lanes[i] = 8'($urandom);
    do_req("rd2", R_OP, 5'h12, 32'h0, 100, -1, got, lat, rd, err);
    chk("rd2_latency", 32'(lat), 32'd36);
    chk("rd2_data", rd, {lanes[3], lanes[2], lanes[1], lanes[0]});
    check_accesses("rd2", R_OP, 5'h12, 32'h0);

    chk("protocol", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
